// File: rtl/wb_data_stage_if.sv
// Memory-side req/ack bus of the write-back data stage. The stage drives it
// through the master modport; the memory model or arbiter uses slave.
interface wb_data_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BYTES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/wb_data_stage.sv
// MEM/WB write-back data stage: req/ack memory access, load alignment and
// extension, and the WB output register. WB_MISALIGN_TRAP_EN adds a misaligned-load trap.
module wb_data_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bubbleW,
  input  logic                    flushW,
  input  logic                    wb_select,
  input  logic [2:0]              load_type,
  input  logic [DATA_WIDTH/8-1:0] write_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  wb_data_stage_if.master         mem,
  output logic                    miss,
  output logic                    mem_err,
`ifdef WB_MISALIGN_TRAP_EN
  output logic                    misalign,
`endif
  output logic [DATA_WIDTH-1:0]   data_WB
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LIM = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state, state_nx;
  logic [WDW-1:0]        wdog;
  logic [OFS-1:0]        ofs;
  logic [2:0]            lt_cur;
  logic                  store, access, trap, done, expire;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [OFS-1:0]        ofs_q;
  logic [2:0]            lt_q;
  logic [DATA_WIDTH-1:0] ext_val, wb_nx;

  // Select the addressed lane and sign/zero-extend it to the datapath width.
  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [DATA_WIDTH-1:0] rd,
    input logic [OFS-1:0]        o,
    input logic [2:0]            lt
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [63:0] r;
    b = 8'(rd >> {o, 3'b000});
    h = 16'(rd >> {o[OFS-1:1], 4'b0000});
    w = (DATA_WIDTH == 64) ? 32'(rd >> {o[OFS-1], 5'b00000}) : 32'(rd);
    case (lt)
      3'd1:    r = {{56{b[7]}}, b};
      3'd2:    r = {{48{h[15]}}, h};
      3'd3:    r = {{32{w[31]}}, w};
      3'd4:    r = {56'd0, b};
      3'd5:    r = {48'd0, h};
      3'd6:    r = {32'd0, w};
      3'd7:    r = 64'(rd);
      default: r = '0;
    endcase
    return DATA_WIDTH'(r);
  endfunction

  assign ofs    = addr[OFS-1:0];
  assign store  = |write_en;
  assign lt_cur = store ? 3'd0 : load_type;
  assign access = store | (load_type != 3'd0);

`ifdef WB_MISALIGN_TRAP_EN
  logic mis_addr;
  always_comb begin
    mis_addr = 1'b0;
    case (lt_cur)
      3'd2, 3'd5: mis_addr = addr[0];
      3'd3, 3'd6: mis_addr = |addr[1:0];
      3'd7:       mis_addr = |addr[2:0];
      default:    mis_addr = 1'b0;
    endcase
  end
  // Only loads carry a size; stores are never trapped.
  assign trap     = (state == IDLE) && mis_addr;
  assign misalign = trap;
`else
  assign trap = 1'b0;
`endif

  assign mem.mem_we    = store;
  assign mem.mem_addr  = {addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
  assign mem.mem_be    = write_en << ofs;
  assign mem.mem_wdata = in_data << {ofs, 3'b000};

  always_comb begin
    state_nx     = state;
    mem.mem_req  = 1'b0;
    miss         = 1'b0;
    mem_err      = 1'b0;
    done         = 1'b0;
    expire       = 1'b0;
    case (state)
      IDLE: begin
        if (access && !trap) begin
          mem.mem_req = 1'b1;
          if (mem.mem_ack) begin
            done = 1'b1;
          end else begin
            miss     = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        mem.mem_req = 1'b1;
        miss        = 1'b1;
        if (mem.mem_ack) begin
          done     = 1'b1;
          miss     = 1'b0;
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && wdog == WD_LIM) begin
          mem.mem_req = 1'b0;
          miss        = 1'b0;
          mem_err     = 1'b1;
          expire      = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nx;
      wdog  <= (state == WAIT && !mem.mem_ack) ? wdog + 1'b1 : '0;
    end
  end

  // Captured access context; an abandoned or trapped load reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      ofs_q   <= '0;
      lt_q    <= '0;
    end else if (done) begin
      rdata_q <= mem.mem_rdata;
      ofs_q   <= ofs;
      lt_q    <= lt_cur;
    end else if (expire || trap) begin
      rdata_q <= '0;
      ofs_q   <= ofs;
      lt_q    <= lt_cur;
    end
  end

  // Completing accesses bypass the capture registers so a zero-wait load
  // lands in data_WB on the edge that ends its MEM cycle.
  assign ext_val = (expire || trap) ? '0
                 : extend(done ? mem.mem_rdata : rdata_q,
                          done ? ofs : ofs_q,
                          done ? lt_cur : lt_q);
  assign wb_nx   = trap ? '0 : (wb_select ? ext_val : DATA_WIDTH'(addr));

  always_ff @(posedge clk) begin
    if (!rst)          data_WB <= '0;
    else if (bubbleW)  data_WB <= data_WB;
    else if (flushW)   data_WB <= '0;
    else if (!miss)    data_WB <= wb_nx;
  end
endmodule

// File: tb/tb_wb_data_stage.sv
// Bench for wb_data_stage: a 32-bit instance (short watchdog) and a 64-bit instance,
// table vectors, hand-written corner sequences and random loads/stores vs a reference model.
module tb_wb_data_stage;
  localparam logic [31:0] IDLE_A = 32'h0000_A5A4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, bub, fl;
  logic        wsel, miss, err;
  logic [2:0]  lt;
  logic [3:0]  we;
  logic [31:0] a, din, wb;
  logic        wsel64, miss64, err64;
  logic [2:0]  lt64;
  logic [7:0]  we64;
  logic [31:0] a64;
  logic [63:0] din64, wb64;
`ifdef WB_MISALIGN_TRAP_EN
  logic        mis, mis64;
`endif
  int checks = 0, failures = 0;

  wb_data_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m32 ();
  wb_data_stage_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) m64 ();

  wb_data_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst), .bubbleW(bub), .flushW(fl), .wb_select(wsel),
    .load_type(lt), .write_en(we), .addr(a), .in_data(din), .mem(m32),
    .miss(miss), .mem_err(err),
`ifdef WB_MISALIGN_TRAP_EN
    .misalign(mis),
`endif
    .data_WB(wb));

  wb_data_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(255)) u64 (
    .clk(clk), .rst(rst), .bubbleW(bub), .flushW(fl), .wb_select(wsel64),
    .load_type(lt64), .write_en(we64), .addr(a64), .in_data(din64), .mem(m64),
    .miss(miss64), .mem_err(err64),
`ifdef WB_MISALIGN_TRAP_EN
    .misalign(mis64),
`endif
    .data_WB(wb64));

  typedef struct {
    logic [2:0]  t;
    logic        ws;
    logic [31:0] ad;
    logic [31:0] rd;
    int          waits;
    logic [31:0] exp;
  } vec32_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] ad;
    logic [63:0] rd;
    logic [63:0] exp;
  } vec64_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd2, 3'd5: return 2;
      3'd3, 3'd6: return 4;
      3'd7:       return 8;
      default:    return 1;
    endcase
  endfunction

  // Reference: pick the size-aligned lane containing the address, then extend.
  function automatic logic [63:0] ref_load(input int dw, input logic [63:0] rd,
                                           input logic [31:0] ad, input logic [2:0] t);
    int nb, o, sz;
    bit sgn;
    logic [63:0] v, mask;
    if (t == 3'd0) return 64'h0;
    nb  = dw / 8;
    sz  = size_of(t);
    sgn = (t == 3'd1 || t == 3'd2 || t == 3'd3);
    if (sz > nb) return 64'h0;
    o = int'(ad % 32'(nb));
    o = o - (o % sz);
    v = rd >> (8 * o);
    mask = (sz == 8) ? ~64'h0 : ((64'h1 << (8 * sz)) - 64'h1);
    v = v & mask;
    if (sgn && sz < 8 && v[8*sz-1]) v = v | ~mask;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic idle32();
    lt = 3'd0; we = 4'd0; wsel = 1'b0; a = IDLE_A; din = 32'h0;
    m32.mem_ack = 1'b0; m32.mem_rdata = 32'h0;
  endtask

  task automatic idle64();
    lt64 = 3'd0; we64 = 8'd0; wsel64 = 1'b0; a64 = IDLE_A; din64 = 64'h0;
    m64.mem_ack = 1'b0; m64.mem_rdata = 64'h0;
  endtask

  // One load (or non-access) on the 32-bit DUT with `waits` wait states.
  task automatic run32(input logic [2:0] t, input logic ws, input logic [31:0] ad,
                       input logic [31:0] rd, input int waits,
                       output int mcyc, output int rq, output logic [31:0] res);
    lt = t; wsel = ws; a = ad; we = 4'd0; din = 32'h0;
    m32.mem_ack   = (waits == 0);
    m32.mem_rdata = (waits == 0) ? rd : $urandom;
    mcyc = 0; rq = 0;
    for (int c = 0; c <= waits; c++) begin
      #2;
      if (miss) mcyc++;
      if (m32.mem_req) rq++;
      if (c == 0 && t != 3'd0) chk("ld mem_addr", 64'(m32.mem_addr), 64'(ad & ~32'h3));
      @(posedge clk); #1;
      m32.mem_ack   = (c + 1 == waits);
      m32.mem_rdata = (c + 1 == waits) ? rd : $urandom;
    end
    idle32();
    res = wb;
  endtask

  task automatic store32(input logic [2:0] t, input logic [31:0] ad,
                         input logic [3:0] w, input logic [31:0] d);
    int o;
    logic [63:0] be_x, wd_x;
    o    = int'(ad % 32'd4);
    be_x = (64'(w) << o) & 64'hF;
    wd_x = (64'(d) << (8 * o)) & 64'hFFFF_FFFF;
    lt = t; we = w; a = ad; din = d; wsel = 1'b0; m32.mem_ack = 1'b1;
    #2;
    chk("st mem_req", 64'(m32.mem_req), 64'd1);
    chk("st mem_we", 64'(m32.mem_we), 64'd1);
    chk("st mem_addr", 64'(m32.mem_addr), 64'(ad - 32'(o)));
    chk("st mem_be", 64'(m32.mem_be), be_x);
    chk("st mem_wdata", 64'(m32.mem_wdata), wd_x);
    chk("st miss", 64'(miss), 64'd0);
    @(posedge clk); #1;
    idle32();
    chk("st data_WB", 64'(wb), 64'(ad));
  endtask

  task automatic run64(input logic [2:0] t, input logic [31:0] ad,
                       input logic [63:0] rd, output logic [63:0] res);
    lt64 = t; wsel64 = 1'b1; a64 = ad; m64.mem_ack = 1'b1; m64.mem_rdata = rd;
    #2;
    chk("64 miss", 64'(miss64), 64'd0);
    chk("64 mem_addr", 64'(m64.mem_addr), 64'(ad & ~32'h7));
    @(posedge clk); #1;
    res = wb64;
    idle64();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    vec32_t tbl[7];
    vec64_t t64[7];
    int mcyc, rq, errs;
    bit seen;
    logic [31:0] res, ad, rd;
    logic [63:0] res64, rd64, exp64;
    logic [2:0] t;
    int waits;

    tbl[0] = '{3'd3, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    tbl[1] = '{3'd1, 1'b1, 32'h0000_0203, 32'h8011_2233, 3, 32'hFFFF_FF80};
    tbl[2] = '{3'd4, 1'b1, 32'h0000_0203, 32'h8011_2233, 3, 32'h0000_0080};
    tbl[3] = '{3'd2, 1'b1, 32'h0000_0202, 32'h8011_2233, 1, 32'hFFFF_8011};
    tbl[4] = '{3'd5, 1'b1, 32'h0000_0200, 32'h8011_2233, 0, 32'h0000_2233};
    tbl[5] = '{3'd1, 1'b1, 32'h0000_0201, 32'h8011_2233, 2, 32'h0000_0022};
    tbl[6] = '{3'd0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 32'h1234_5678};

    t64[0] = '{3'd6, 32'h4, 64'hF000_0001_0000_0000, 64'h0000_0000_F000_0001};
    t64[1] = '{3'd3, 32'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    t64[2] = '{3'd7, 32'h8, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    t64[3] = '{3'd1, 32'h7, 64'hFE00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
    t64[4] = '{3'd5, 32'h6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
    t64[5] = '{3'd2, 32'h2, 64'h0000_0000_C001_0000, 64'hFFFF_FFFF_FFFF_C001};
    t64[6] = '{3'd4, 32'h3, 64'h0000_0000_AB00_0000, 64'h0000_0000_0000_00AB};

    rst = 1'b0; bub = 1'b0; fl = 1'b0;
    idle32(); idle64();
    repeat (2) @(posedge clk);
    #1;
    chk("rst miss", 64'(miss), 64'd0);
    chk("rst mem_err", 64'(err), 64'd0);
    chk("rst mem_req", 64'(m32.mem_req), 64'd0);
    chk("rst data_WB", 64'(wb), 64'd0);
    chk("rst data_WB64", wb64, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run32(tbl[i].t, tbl[i].ws, tbl[i].ad, tbl[i].rd, tbl[i].waits, mcyc, rq, res);
      chk($sformatf("vec%0d data_WB", i), 64'(res), 64'(tbl[i].exp));
      chk($sformatf("vec%0d miss_cycles", i), 64'(mcyc), 64'(tbl[i].t != 0 ? tbl[i].waits : 0));
      chk($sformatf("vec%0d req_cycles", i), 64'(rq), 64'(tbl[i].t != 0 ? tbl[i].waits + 1 : 0));
    end

    // SB to byte 1
    lt = 3'd0; we = 4'b0001; a = 32'h31; din = 32'hAB; m32.mem_ack = 1'b1;
    #2;
    chk("sb mem_be", 64'(m32.mem_be), 64'h2);
    chk("sb mem_wdata", 64'(m32.mem_wdata), 64'h0000_AB00);
    chk("sb mem_we", 64'(m32.mem_we), 64'd1);
    chk("sb mem_addr", 64'(m32.mem_addr), 64'h30);
    @(posedge clk); #1;
    idle32();

    // Watchdog expiry with TIMEOUT=4
    @(posedge clk); #1;
    chk("pre_timeout data_WB", 64'(wb), 64'(IDLE_A));
    lt = 3'd3; wsel = 1'b1; a = 32'h40;
    mcyc = 0; errs = 0; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      #2;
      if (miss) mcyc++;
      if (err) begin
        errs++;
        seen = 1'b1;
        chk("expiry mem_req", 64'(m32.mem_req), 64'd0);
      end
      @(posedge clk); #1;
    end
    idle32();
    chk("timeout mem_err seen", 64'(seen), 64'd1);
    chk("timeout miss_cycles", 64'(mcyc), 64'd4);
    chk("timeout err_pulses", 64'(errs), 64'd1);
    chk("timeout data_WB", 64'(wb), 64'd0);
    #2;
    chk("post_timeout mem_req", 64'(m32.mem_req), 64'd0);
    chk("post_timeout mem_err", 64'(err), 64'd0);

    // Bubble holds, flush clears
    @(posedge clk); #1;
    chk("pre_bubble data_WB", 64'(wb), 64'(IDLE_A));
    lt = 3'd3; wsel = 1'b1; a = 32'h100; m32.mem_ack = 1'b1; m32.mem_rdata = 32'h1234_5678; bub = 1'b1;
    @(posedge clk); #1;
    bub = 1'b0;
    idle32();
    chk("bubble hold data_WB", 64'(wb), 64'(IDLE_A));
    lt = 3'd3; wsel = 1'b1; a = 32'h100; m32.mem_ack = 1'b1; m32.mem_rdata = 32'h1234_5678; fl = 1'b1;
    @(posedge clk); #1;
    fl = 1'b0;
    idle32();
    chk("flush data_WB", 64'(wb), 64'd0);

    // Reset in the middle of a wait
    @(posedge clk); #1;
    lt = 3'd3; wsel = 1'b1; a = 32'h80;
    @(posedge clk); #1;
    #1;
    chk("wait mem_req", 64'(m32.mem_req), 64'd1);
    chk("wait miss", 64'(miss), 64'd1);
    rst = 1'b0; idle32();
    #1;
    chk("rst_edge_pending mem_req", 64'(m32.mem_req), 64'd1);
    @(posedge clk); #1;
    chk("after_rst mem_req", 64'(m32.mem_req), 64'd0);
    chk("after_rst miss", 64'(miss), 64'd0);
    chk("after_rst data_WB", 64'(wb), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef WB_MISALIGN_TRAP_EN
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      lt = (i == 0) ? 3'd3 : 3'd2; wsel = 1'b1; a = (i == 0) ? 32'h2 : 32'h201;
      m32.mem_ack = 1'b1; m32.mem_rdata = 32'hCAFE_F00D;
      #2;
      chk("trap misalign", 64'(mis), 64'd1);
      chk("trap mem_req", 64'(m32.mem_req), 64'd0);
      chk("trap miss", 64'(miss), 64'd0);
      @(posedge clk); #1;
      idle32();
      chk("trap data_WB", 64'(wb), 64'd0);
      #2;
      chk("trap pulse end", 64'(mis), 64'd0);
    end
`else
    run32(3'd3, 1'b1, 32'h202, 32'hCAFE_F00D, 0, mcyc, rq, res);
    chk("misaligned lw aligned_down", 64'(res), 64'hCAFE_F00D);
    chk("misaligned lw req", 64'(rq), 64'd1);
`endif

    for (int i = 0; i < 50; i++) begin
      ad = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        store32(3'($urandom_range(0, 5)), ad, 4'($urandom_range(1, 15)), $urandom);
      end else begin
        t = 3'($urandom_range(0, 5));
`ifdef WB_MISALIGN_TRAP_EN
        ad = ad & ~(32'(size_of(t)) - 32'd1);
`endif
        waits = (t == 3'd0) ? 0 : int'($urandom_range(0, 3));
        rd = $urandom;
        run32(t, t != 3'd0, ad, rd, waits, mcyc, rq, res);
        chk($sformatf("rnd%0d data_WB", i), 64'(res),
            (t != 3'd0) ? ref_load(32, 64'(rd), ad, t) : 64'(ad));
        chk($sformatf("rnd%0d miss_cycles", i), 64'(mcyc), 64'(waits));
      end
    end

    for (int i = 0; i < 7; i++) begin
      run64(t64[i].t, t64[i].ad, t64[i].rd, res64);
      chk($sformatf("vec64_%0d data_WB", i), res64, t64[i].exp);
    end

    for (int i = 0; i < 30; i++) begin
      t = 3'($urandom_range(1, 7));
      ad = $urandom;
`ifdef WB_MISALIGN_TRAP_EN
      ad = ad & ~(32'(size_of(t)) - 32'd1);
`endif
      rd64 = {$urandom, $urandom};
      exp64 = ref_load(64, rd64, ad, t);
      run64(t, ad, rd64, res64);
      chk($sformatf("rnd64_%0d data_WB", i), res64, exp64);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_data_stage.md
Name: wb_data_stage

Overview:
- Parametrised MEM/WB write-back data stage.
- Issues load/store accesses to an external memory port with a req/ack handshake, with any number of wait states.
- Aligns load data and sign/zero-extends it, then registers the write-back value with bubble/flush support.
- Asserts miss to stall the pipeline while an access is outstanding; a watchdog flags hung accesses.

Parameters:
- DATA_WIDTH, 32, datapath width; legal values 32 or 64. BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT, 255, watchdog limit in wait cycles; 0 disables the watchdog. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- bubbleW  in  1  hold the WB output register.
- flushW  in  1  clear the WB output register.
- wb_select  in  1  0: write back addr (ALU result); 1: write back extended load data.
- load_type  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD. Codes 6 and 7 are legal only when DATA_WIDTH=64.
- write_en  in  BYTES  store byte mask, lane-0 aligned.
- addr  in  ADDR_WIDTH  byte address / ALU result.
- in_data  in  DATA_WIDTH  store data, lane-0 aligned.
- mem_req  out  1  access request.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_WIDTH  word-aligned address (low OFS bits zero).
- mem_be  out  BYTES  write_en shifted left by addr[OFS-1:0].
- mem_wdata  out  DATA_WIDTH  in_data shifted left by 8*addr[OFS-1:0].
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read word.
- miss  out  1  stall request to the hazard unit.
- mem_err  out  1  one-cycle pulse on watchdog expiry.
- data_WB  out  DATA_WIDTH  write-back value.

Behaviour:
- Access definition:
  - access = (load_type != 0) | (|write_en).
  - Load and store in the same cycle is illegal; if it occurs, the store wins.
- FSM states: IDLE, WAIT.
- IDLE:
  - access=1: mem_req=1 combinationally from the inputs.
  - mem_ack=1 in the same cycle: zero-wait completion, miss=0, stay in IDLE.
  - mem_ack=0: miss=1, go to WAIT, wdog cleared to 0.
- WAIT:
  - mem_req=1 and miss=1; the pipeline guarantees MEM-stage inputs stay stable while miss=1.
  - mem_ack=1: miss=0, go to IDLE.
  - Otherwise wdog increments by 1.
- Watchdog: when TIMEOUT!=0 and wdog==TIMEOUT-1 with no ack:
  - pulse mem_err for one cycle, drop mem_req, go to IDLE, miss=0.
  - The load result is forced to 0.
- Read capture: on completion, mem_rdata is latched into rdata_q together with addr low bits and load_type.
- Extension:
  - Select lane by addr_q[OFS-1:0] (byte) or addr_q[OFS-1:1] (half), and by addr_q[2] for a word when DATA_WIDTH=64.
  - Signed codes sign-extend to DATA_WIDTH; unsigned codes zero-extend.
  - LW on DATA_WIDTH=32 passes the word through unchanged.
- WB register update, at each rising edge, in priority order:
  1. rst=0: data_WB=0.
  2. bubbleW: hold.
  3. flushW: 0.
  4. miss: hold.
  5. Otherwise: wb_select ? extended(rdata) : addr zero-extended or truncated to DATA_WIDTH.
- Latency: a zero-wait load appears on data_WB one edge after the MEM cycle; N wait states add N cycles.
- Flush during WAIT does not abort the memory access; the result is discarded by the flush priority.
- Reset values: state IDLE, wdog=0, mem_req=0, miss=0, mem_err=0, data_WB=0, all captured registers 0.
- Reset asserted mid-access: mem_req drops in the cycle after the reset edge. Memory must tolerate an abandoned request.
- Stores: data_WB follows the wb_select rule; the pipeline drives wb_select=0.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, or an LD with addr[2:0]!=0, is blocked: no mem_req is issued, misalign pulses for one cycle, miss=0, and the data_WB update writes 0.
- Undefined:
  - No port is added.
  - Offending low address bits are ignored: the access uses the aligned-down lane. No trap.

Test Plan:
- LW addr=0x104, zero-wait ack, rdata=0xDEADBEEF, wb_select=1 -> mem_addr=0x104, miss never asserted, data_WB=0xDEADBEEF next edge.
- LB addr=0x203, 3 wait states, rdata=0x80112233 -> miss high for 3 cycles, data_WB=0xFFFFFF80. Same with LBU -> 0x00000080.
- SB addr=0x31, in_data=0xAB, write_en=0001 -> mem_be=0010, mem_wdata=0x0000AB00, mem_we=1, mem_addr=0x30.
- TIMEOUT=4, ack never arrives -> miss high for 4 cycles, mem_err pulses once, mem_req low afterwards, data_WB=0.
- bubbleW=1 during a completing load -> data_WB holds its previous value. flushW=1 -> data_WB=0. rst=0 mid-WAIT -> state IDLE, mem_req=0 next cycle.
- DATA_WIDTH=64, LWU addr=0x4, rdata=0xF0000001_00000000 -> data_WB=0x00000000_F0000001. With WB_MISALIGN_TRAP_EN, LW addr=0x2 -> misalign=1, mem_req=0.
